// File: rtl/rf_scan_ctrl.sv
// Debug scanner sharing regfile read port 2 with the CPU: snapshots x0..x(NREGS-1),
// accumulates a checksum, and serves the snapshot through a registered query port.
module rf_scan_ctrl #(
   parameter int NREGS    = 32,
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          cpu_rd_req,
   input  logic [AW-1:0] cpu_raddr,
   output logic [AW-1:0] rf_raddr,
   input  logic [DW-1:0] rf_rdata,
   output logic          cpu_stall,
   output logic          scan_busy,
   output logic          scan_done,
   output logic          snap_valid,
   output logic [DW-1:0] checksum,
   input  logic [AW-1:0] query_addr,
   output logic [DW-1:0] query_data
);

   localparam int             WCW      = $clog2(MAX_WAIT + 2);
   localparam logic [AW-1:0]  LAST_IDX = AW'(NREGS - 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
   localparam logic [WCW-1:0] STALL_AT = (MAX_WAIT == 0) ? '0 : WCW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   state_t         state_reg, state_next;
   logic [AW-1:0]  idx_reg;
   logic [WCW-1:0] wait_cnt_reg;
   logic           stall_reg;
   logic           valid_reg;
   logic [DW-1:0]  sum_reg;
   logic [DW-1:0]  query_reg;
   logic [DW-1:0]  snap_reg [NREGS];

   logic capture;
   logic denied;
   logic stall_hit;

   // Next-state, port mux and status outputs
   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      denied     = 1'b0;
      rf_raddr   = cpu_raddr;
      scan_busy  = 1'b0;
      scan_done  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            scan_busy = 1'b1;
            capture   = ~cpu_rd_req | stall_reg;
            denied    = ~capture;
            // Reset hands the port straight back to the CPU in the cycle it is sampled.
            if (capture && !rst) begin
               rf_raddr = idx_reg;
            end
            if (capture && (idx_reg == LAST_IDX)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            scan_done  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The denied cycle that completes MAX_WAIT consecutive denials raises the stall.
   assign stall_hit = denied && (MAX_WAIT != 0) && (wait_cnt_reg == STALL_AT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg      <= '0;
         wait_cnt_reg <= '0;
         stall_reg    <= 1'b0;
         valid_reg    <= 1'b0;
         sum_reg      <= '0;
         query_reg    <= '0;
      end else begin
         query_reg <= snap_reg[query_addr];
         if (state_reg == ST_IDLE && start) begin
            idx_reg      <= '0;
            sum_reg      <= '0;
            valid_reg    <= 1'b0;
            wait_cnt_reg <= '0;
            stall_reg    <= 1'b0;
         end
         if (state_reg == ST_DONE) begin
            valid_reg <= 1'b1;
         end
         if (capture) begin
            sum_reg      <= sum_reg + rf_rdata;
            wait_cnt_reg <= '0;
            stall_reg    <= 1'b0;
            if (idx_reg != LAST_IDX) begin
               idx_reg <= idx_reg + AW'(1);
            end
         end else if (denied) begin
            if (wait_cnt_reg != WAIT_MAX) begin
               wait_cnt_reg <= wait_cnt_reg + WCW'(1);
            end
            if (stall_hit) begin
               stall_reg <= 1'b1;
            end
         end
      end
   end

   // Snapshot must read back as zeros after reset, so it lives in flops rather than RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            snap_reg[i] <= '0;
         end
      end else if (capture) begin
         snap_reg[idx_reg] <= rf_rdata;
      end
   end

   assign cpu_stall  = stall_reg;
   assign snap_valid = valid_reg;
   assign checksum   = sum_reg;
   assign query_data = query_reg;

endmodule
